// File: rtl/shift_arbiter.sv
// Two-port round-robin front end sharing one 32-bit logical barrel shifter.
// Each accepted request produces one result in a single registered slot with a requester tag.
module shift_arbiter #(
   parameter int WIDTH = 32,
   parameter int SHIFT = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rq0_valid,
   output logic             rq0_ready,
   input  logic [WIDTH-1:0] rq0_a,
   input  logic [SHIFT-1:0] rq0_b,
   input  logic             rq0_dir,
   input  logic             rq1_valid,
   output logic             rq1_ready,
   input  logic [WIDTH-1:0] rq1_a,
   input  logic [SHIFT-1:0] rq1_b,
   input  logic             rq1_dir,
   output logic             rs_valid,
   input  logic             rs_ready,
   output logic             rs_id,
   output logic [WIDTH-1:0] rs_data
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both high.
   // Request ready may depend on valid; result valid never depends on rs_ready.
   logic             last_grant;
   logic             slot_free;
   logic             grant_any;
   logic             grant_id;
   logic             accept;
   logic [WIDTH-1:0] sh_a;
   logic [SHIFT-1:0] sh_b;
   logic             sh_dir;
   logic [WIDTH-1:0] sh_out;

   assign slot_free = ~rs_valid | rs_ready;

   always_comb begin
      grant_any = 1'b0;
      grant_id  = 1'b0;
      if (rq0_valid && rq1_valid) begin
         grant_any = 1'b1;
         grant_id  = ~last_grant;
      end else if (rq0_valid) begin
         grant_any = 1'b1;
         grant_id  = 1'b0;
      end else if (rq1_valid) begin
         grant_any = 1'b1;
         grant_id  = 1'b1;
      end
   end

   assign accept    = ~rst & slot_free & grant_any;
   assign rq0_ready = accept & ~grant_id;
   assign rq1_ready = accept & grant_id;

   assign sh_a   = grant_id ? rq1_a   : rq0_a;
   assign sh_b   = grant_id ? rq1_b   : rq0_b;
   assign sh_dir = grant_id ? rq1_dir : rq0_dir;

   // Logarithmic shifter: stage i moves the operand by 2**i when bit i of the amount is set.
   always_comb begin
      sh_out = sh_a;
      for (int i = 0; i < SHIFT; i++) begin
         if (sh_b[i]) begin
            sh_out = sh_dir ? (sh_out >> (1 << i)) : (sh_out << (1 << i));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_valid   <= 1'b0;
         rs_data    <= '0;
         rs_id      <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         rs_valid   <= 1'b1;
         rs_data    <= sh_out;
         rs_id      <= grant_id;
         last_grant <= grant_id;
      end else if (rs_ready) begin
         rs_valid   <= 1'b0;
      end
   end

endmodule
